ahb_rom_ctrl: RTL and testbench
===============================

Name: ahb_rom_ctrl

Overview:
AHB-Lite slave front-end that sequences a synchronous-read ROM array (16K x 32, word-addressed) onto the multicycle ARM AHB bus. Accepts address phases, drives the ROM read enable and address, inserts a configurable number of wait states via HREADYOUT, and returns a two-cycle ERROR response for writes and illegal transfers. Sits between the AHB decoder/mux and the ROM array; the ROM array becomes a pure storage element with a registered read port.

Parameters:
WAIT_STATES, 0, HREADYOUT-low cycles inserted per read data phase (0..7).
ADDR_W, 16, byte-address width of HADDR seen by this slave.
ROM_AW, 14, ROM word-address width (ADDR_W-2).

Ports:
HCLK  in  1  bus clock, all logic on posedge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  ADDR_W  byte address.
HTRANS  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
HWRITE  in  1  write flag.
HSIZE  in  3  transfer size.
HREADY  in  1  bus-level ready (from mux).
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data.
rom_en  out  1  ROM read strobe.
rom_addr  out  ROM_AW  ROM word address.
rom_rdata  in  32  ROM registered output; valid the cycle after rom_en, holds while rom_en=0.

Behaviour:
- Reset (HRESET=1 at posedge): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, rom_en=0, rom_addr=0, wait counter=0. Reset mid-transfer abandons it; no ERROR issued.
- Accept = HSEL & HREADY & HTRANS[1]. Sampled only when HREADYOUT=1.
- Legal read: HWRITE=0, HSIZE<=2, address naturally aligned for HSIZE. Anything else accepted is illegal.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE/DATA + legal read accept: rom_en=1 combinationally, rom_addr=HADDR[ADDR_W-1:2]; next = WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES) else DATA.
- WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; at counter==1 next=DATA.
- DATA: HREADYOUT=1, HRESP=0, HRDATA=rom_rdata. New accept in DATA is pipelined (back-to-back reads, no bubble when WAIT_STATES=0). No accept -> IDLE.
- Illegal accept: no rom_en; next=ERR1. ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1; accepts new address phase like DATA.
- IDLE/BUSY transfers or HSEL=0: zero-wait OKAY, state unchanged to IDLE.
- HREADY=0 from another slave while ours is IDLE: no accept.
- Read latency: WAIT_STATES+1 cycles from address phase to HREADYOUT=1 data phase.
- HRDATA outside DATA: holds last value (not required zero).

Optional Feature:
AHB_ROM_RDBUF_EN: one-entry read buffer (tag=word address, valid bit cleared by reset). Accepted legal read hitting the buffer skips WAIT (zero wait states) and returns buffer data; rom_en not asserted. Every completed DATA phase reloads buffer. Without macro: every read goes to ROM with full WAIT_STATES.

Decomposition:
- Package ahb_pkg: HTRANS encodings, HRESP encodings, HSIZE_WORD constant, ctrl state enum.
- No sub-module required; optional read buffer may be a small sub-module ahb_rdbuf.

Test Plan:
- WAIT_STATES=0, NONSEQ read 0x0010 then SEQ 0x0014 back-to-back -> rom_addr 4 then 5, HRDATA=rom[4] then rom[5] on consecutive cycles, HREADYOUT stays 1.
- WAIT_STATES=3, read 0x0100 -> HREADYOUT low exactly 3 cycles, then 1 with HRDATA=rom[64], HRESP=0.
- Write to 0x0020 -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (HREADYOUT=1,HRESP=1), rom_en never asserted; following read completes OKAY.
- Word read at 0x0002 (HSIZE=2) -> two-cycle ERROR; halfword read at 0x0002 -> OKAY, rom_addr=0.
- HRESET asserted in WAIT cycle 2 of 3 -> next cycle HREADYOUT=1, HRESP=0, state IDLE; new read completes normally.
- With AHB_ROM_RDBUF_EN, WAIT_STATES=2: read 0x0040 twice -> first takes 2 waits, second zero waits, rom_en pulses once.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, controller state type and transfer-legality
// helper shared by the ahb_rom_ctrl slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ctrl_state_e;

  // True when the transfer size fits the 32-bit port and the address is naturally aligned.
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = (lsb[0] == 1'b0);
      HSIZE_WORD: ok = (lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_rom_ctrl.sv
// ahb_rom_ctrl: AHB-Lite slave sequencing a synchronous-read ROM with WAIT_STATES
// wait states and two-cycle ERROR responses. Define AHB_ROM_RDBUF_EN for a one-entry read buffer.
module ahb_rom_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ROM_AW      = 14
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  ctrl_state_e       state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hold_q;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [ROM_AW-1:0] word_addr_s;
  logic [31:0]       data_s;
  logic              accept_s, legal_s, take_s, hit_s, rom_en_s;

  assign word_addr_s = HADDR[ROM_AW+1:2];
  // hreadyout_q is high exactly in IDLE, DATA and ERR2, the states that sample an address phase
  assign accept_s    = hreadyout_q & HSEL & HREADY &
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign legal_s     = ~HWRITE & size_aligned(HSIZE, HADDR[1:0]);
  assign take_s      = accept_s & legal_s;

`ifdef AHB_ROM_RDBUF_EN
  logic              buf_valid_q;
  logic [ROM_AW-1:0] buf_tag_q;
  logic [31:0]       buf_data_q;
  logic              buf_sel_q;
  logic [ROM_AW-1:0] daddr_q;

  assign hit_s  = buf_valid_q & (buf_tag_q == word_addr_s);
  assign data_s = buf_sel_q ? buf_data_q : rom_rdata;

  // Read buffer: reloaded with the word returned by every completed data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= 32'h0000_0000;
      buf_sel_q   <= 1'b0;
      daddr_q     <= '0;
    end else begin
      buf_sel_q <= take_s & hit_s;
      if (take_s) begin
        daddr_q <= word_addr_s;
      end
      if (state_q == ST_DATA) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= daddr_q;
        buf_data_q  <= data_s;
      end
    end
  end
`else
  assign hit_s  = 1'b0;
  assign data_s = rom_rdata;
`endif

  // Next-state, wait counter and ROM strobe decode.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    rom_en_s = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q <= 3'd1) begin
          state_d = ST_DATA;
          wcnt_d  = 3'd0;
        end else begin
          wcnt_d  = wcnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (take_s) begin
          if (hit_s) begin
            state_d = ST_DATA;
          end else begin
            rom_en_s = 1'b1;
            addr_d   = word_addr_s;
            if (WS != 3'd0) begin
              state_d = ST_WAIT;
              wcnt_d  = WS;
            end else begin
              state_d = ST_DATA;
            end
          end
        end else if (accept_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 3'd0;
      end
    endcase
  end

  // Handshake outputs for the next cycle, derived from the next state.
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    case (state_d)
      ST_WAIT: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
    endcase
  end

  // Controller state and registered handshake outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      addr_q      <= '0;
      hold_q      <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      addr_q      <= addr_d;
      hold_q      <= HRDATA;
    end
  end

  // ROM output is only valid in the data cycle itself, so read data is muxed, then held.
  assign HRDATA    = (state_q == ST_DATA) ? data_s : hold_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign rom_en    = rom_en_s & ~HRESET;
  assign rom_addr  = rom_en_s ? word_addr_s : addr_q;

endmodule

// File: tb/tb_ahb_rom_ctrl.sv
// Self-checking bench for ahb_rom_ctrl: a table of per-cycle vectors on a zero-wait
// instance plus hand-written multi-cycle sequences on a three-wait instance.
module tb_ahb_rom_ctrl;

  logic HCLK;
  int   errs = 0;
  int   checks = 0;

  // Zero-wait instance
  logic        rst0, hsel0, hwrite0, hready0, hreadyout0, hresp0, rom_en0;
  logic [15:0] haddr0;
  logic [1:0]  htrans0;
  logic [2:0]  hsize0;
  logic [31:0] hrdata0, rom_rdata0;
  logic [13:0] rom_addr0;

  // Three-wait instance
  logic        rst3, hsel3, hwrite3, hready3, hreadyout3, hresp3, rom_en3;
  logic [15:0] haddr3;
  logic [1:0]  htrans3;
  logic [2:0]  hsize3;
  logic [31:0] hrdata3, rom_rdata3;
  logic [13:0] rom_addr3;

  ahb_rom_ctrl #(.WAIT_STATES(0), .ADDR_W(16), .ROM_AW(14)) dut0 (
    .HCLK(HCLK), .HRESET(rst0), .HSEL(hsel0), .HADDR(haddr0), .HTRANS(htrans0),
    .HWRITE(hwrite0), .HSIZE(hsize0), .HREADY(hready0), .HREADYOUT(hreadyout0),
    .HRESP(hresp0), .HRDATA(hrdata0), .rom_en(rom_en0), .rom_addr(rom_addr0),
    .rom_rdata(rom_rdata0)
  );

  ahb_rom_ctrl #(.WAIT_STATES(3), .ADDR_W(16), .ROM_AW(14)) dut3 (
    .HCLK(HCLK), .HRESET(rst3), .HSEL(hsel3), .HADDR(haddr3), .HTRANS(htrans3),
    .HWRITE(hwrite3), .HSIZE(hsize3), .HREADY(hready3), .HREADYOUT(hreadyout3),
    .HRESP(hresp3), .HRDATA(hrdata3), .rom_en(rom_en3), .rom_addr(rom_addr3),
    .rom_rdata(rom_rdata3)
  );

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    return 32'hC0DE_0000 ^ {18'h0, a} ^ {4'h0, a, 14'h0};
  endfunction

  // Registered-read ROM models, output holds while rom_en is low.
  always @(posedge HCLK) begin
    if (rom_en0) rom_rdata0 <= rom_word(rom_addr0);
    if (rom_en3) rom_rdata3 <= rom_word(rom_addr3);
  end

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic        rdy;
    logic        e_rdy;
    logic        e_resp;
    logic        e_en;
    logic [13:0] e_addr;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 25;
  vec_t vt[NV];

  function automatic vec_t mk(input logic sel, input logic [15:0] addr, input logic [1:0] trans,
                              input logic wr, input logic [2:0] size, input logic rdy,
                              input logic e_rdy, input logic e_resp, input logic e_en,
                              input logic [13:0] e_addr, input logic chk_data,
                              input logic [31:0] e_data);
    vec_t v;
    v.sel = sel; v.addr = addr; v.trans = trans; v.wr = wr; v.size = size; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_en = e_en; v.e_addr = e_addr;
    v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive3(input logic sel, input logic [15:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size);
    hsel3 = sel; haddr3 = addr; htrans3 = trans; hwrite3 = wr; hsize3 = size; hready3 = 1'b1;
  endtask

  // Issues one word read on the three-wait instance and follows it to its data phase.
  task automatic read3(input logic [15:0] a, input int exp_waits, input string tag,
                       output int ens);
    int waits;
    bit done;
    @(posedge HCLK); #1;
    drive3(1'b1, a, 2'b10, 1'b0, 3'd2);
    @(negedge HCLK);
    ens = rom_en3 ? 1 : 0;
    waits = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge HCLK); #1;
      drive3(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0);
      @(negedge HCLK);
      if (rom_en3) ens++;
      if (hreadyout3) done = 1'b1;
      else waits++;
    end
    chk({tag, " completes"}, 32'(done), 32'd1);
    chk({tag, " wait cycles"}, 32'(waits), 32'(exp_waits));
    chk({tag, " hresp"}, 32'(hresp3), 32'd0);
    chk({tag, " hrdata"}, hrdata3, rom_word(a[15:2]));
  endtask

  initial begin
    int en_a, en_b, en_c;
    int buf_waits;
`ifdef AHB_ROM_RDBUF_EN
    buf_waits = 0;
`else
    buf_waits = 3;
`endif

    //        sel  addr      tr     wr    sz    rdy   e_rdy e_rsp e_en  e_addr  chk  e_data
    vt[0]  = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, 32'h0);
    vt[1]  = mk(1'b1, 16'h0010, 2'b10, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 14'd4,  1'b0, 32'h0);
    vt[2]  = mk(1'b1, 16'h0014, 2'b11, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 14'd5,  1'b1, rom_word(14'd4));
    vt[3]  = mk(1'b1, 16'h0000, 2'b00, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd5));
    vt[4]  = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd5));
    vt[5]  = mk(1'b1, 16'h0020, 2'b10, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[6]  = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[7]  = mk(1'b1, 16'h0008, 2'b10, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 14'd2,  1'b0, 32'h0);
    vt[8]  = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd2));
    vt[9]  = mk(1'b1, 16'h0002, 2'b10, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[10] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[11] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[12] = mk(1'b1, 16'h0002, 2'b10, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 14'd0,  1'b0, 32'h0);
    vt[13] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd0));
    vt[14] = mk(1'b1, 16'h0030, 2'b01, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[15] = mk(1'b1, 16'h0030, 2'b10, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd0));
    vt[16] = mk(1'b0, 16'h0030, 2'b10, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[17] = mk(1'b1, 16'h0001, 2'b10, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[18] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[19] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[20] = mk(1'b1, 16'h0033, 2'b10, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 14'd12, 1'b0, 32'h0);
    vt[21] = mk(1'b1, 16'h0040, 2'b11, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd12));
    vt[22] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[23] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0,  1'b0, 32'h0);
    vt[24] = mk(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0,  1'b1, rom_word(14'd12));

    rst0 = 1'b1; hsel0 = 1'b0; haddr0 = 16'h0; htrans0 = 2'b00; hwrite0 = 1'b0;
    hsize0 = 3'd0; hready0 = 1'b1;
    rst3 = 1'b1;
    drive3(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0);
    repeat (2) @(posedge HCLK);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    @(negedge HCLK);
    chk("reset rom_addr0", 32'(rom_addr0), 32'd0);
    chk("reset rom_en3", 32'(rom_en3), 32'd0);
    chk("reset hreadyout3", 32'(hreadyout3), 32'd1);
    chk("reset hresp3", 32'(hresp3), 32'd0);
    chk("reset hrdata3", hrdata3, 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(posedge HCLK); #1;
      hsel0 = vt[i].sel; haddr0 = vt[i].addr; htrans0 = vt[i].trans;
      hwrite0 = vt[i].wr; hsize0 = vt[i].size; hready0 = vt[i].rdy;
      @(negedge HCLK);
      chk($sformatf("v%0d hreadyout", i), 32'(hreadyout0), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d hresp", i), 32'(hresp0), 32'(vt[i].e_resp));
      chk($sformatf("v%0d rom_en", i), 32'(rom_en0), 32'(vt[i].e_en));
      if (vt[i].e_en) chk($sformatf("v%0d rom_addr", i), 32'(rom_addr0), 32'(vt[i].e_addr));
      if (vt[i].chk_data) chk($sformatf("v%0d hrdata", i), hrdata0, vt[i].e_data);
    end

    read3(16'h0100, 3, "ws3 read 0x100", en_a);
    chk("ws3 read 0x100 rom_en pulses", 32'(en_a), 32'd1);

    // Same word twice, separated by an idle cycle so the first data phase has retired.
    @(posedge HCLK); #1;
    drive3(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0);
    read3(16'h0040, 3, "buf first read", en_b);
    @(posedge HCLK); #1;
    drive3(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0);
    read3(16'h0040, buf_waits, "buf second read", en_c);
    chk("buf rom_en pulses", 32'(en_b + en_c), (buf_waits == 0) ? 32'd1 : 32'd2);

    // Reset during the second of three wait cycles abandons the transfer.
    @(posedge HCLK); #1;
    drive3(1'b1, 16'h0200, 2'b10, 1'b0, 3'd2);
    @(negedge HCLK);
    chk("rst seq rom_en", 32'(rom_en3), 32'd1);
    chk("rst seq rom_addr", 32'(rom_addr3), 32'h80);
    @(posedge HCLK); #1;
    drive3(1'b0, 16'h0000, 2'b00, 1'b0, 3'd0);
    @(negedge HCLK);
    chk("rst seq wait1 hreadyout", 32'(hreadyout3), 32'd0);
    @(posedge HCLK); #1;
    rst3 = 1'b1;
    @(negedge HCLK);
    chk("rst seq wait2 hreadyout", 32'(hreadyout3), 32'd0);
    @(posedge HCLK); #1;
    rst3 = 1'b0;
    @(negedge HCLK);
    chk("rst seq after hreadyout", 32'(hreadyout3), 32'd1);
    chk("rst seq after hresp", 32'(hresp3), 32'd0);
    chk("rst seq after hrdata", hrdata3, 32'd0);
    read3(16'h0204, 3, "post-reset read", en_a);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
